// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP_RISC execute/writeback slice.
//   - br_kind_e : branch-kind encodings carried on in_br_type
//   - LINK_REG  : default destination register for bl link writes
//   - PC_STEP   : byte distance to the next sequential instruction
package kgp_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_UNC  = 3'd1,  // br
    BR_LTZ  = 3'd2,  // bltz
    BR_Z    = 3'd3,  // bz
    BR_NZ   = 3'd4,  // bnz
    BR_L    = 3'd5,  // bl
    BR_CY   = 3'd6,  // bcy
    BR_NCY  = 3'd7   // bncy
  } br_kind_e;

  localparam logic [4:0]  LINK_REG = 5'd31;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Writeback entry held by the stage's output buffer.
  typedef struct packed {
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
  } wb_entry_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch resolution from ALU flags and the registered carry.
// Ports:
//   br_type : branch kind (kgp_pkg::br_kind_e encoding)
//   zero    : ALU zero flag
//   msb     : ALU msb flag
//   carry_q : architectural carry before this cycle's update
//   taken   : branch is taken
module branch_cond
  import kgp_pkg::*;
(
  input  logic [2:0] br_type,
  input  logic       zero,
  input  logic       msb,
  input  logic       carry_q,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (br_kind_e'(br_type))
      BR_NONE: taken = 1'b0;
      BR_UNC:  taken = 1'b1;
      BR_LTZ:  taken = msb;
      BR_Z:    taken = zero;
      BR_NZ:   taken = !zero;
      BR_L:    taken = 1'b1;
      BR_CY:   taken = carry_q;
      BR_NCY:  taken = !carry_q;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute/writeback stage: registers the ALU result for writeback through a
// single-entry valid/ready buffer, holds the carry flag, and turns taken
// branches into a one-cycle PC redirect pulse.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_valid / in_ready        : upstream handshake
//   in_result, in_zero, in_msb, in_carry, in_op_add : ALU outputs / op class
//   in_wr_en, in_rd            : destination write request
//   in_br_type, in_pc, in_br_target : branch kind, PC, resolved target
//   out_valid / out_ready      : writeback handshake
//   out_wb_en, out_wb_rd, out_wb_data : register-file write port
//   redirect_valid, redirect_pc: one-cycle redirect pulse and target
//   carry_q                    : architectural carry flag
module ex_wb_stage
  import kgp_pkg::*;
#(
  parameter logic [4:0] LINK_REG = kgp_pkg::LINK_REG
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_zero,
  input  logic        in_msb,
  input  logic        in_carry,
  input  logic        in_op_add,
  input  logic        in_wr_en,
  input  logic [4:0]  in_rd,
  input  logic [2:0]  in_br_type,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_br_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_wb_en,
  output logic [4:0]  out_wb_rd,
  output logic [31:0] out_wb_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        carry_q
);

  logic      acc;
  logic      taken;
  logic      is_bl;
  wb_entry_t nxt;
  wb_entry_t ent;

  // Drain and fill may happen in the same cycle, so no bubble.
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign is_bl    = (br_kind_e'(in_br_type) == BR_L);

  branch_cond u_cond (
    .br_type (in_br_type),
    .zero    (in_zero),
    .msb     (in_msb),
    .carry_q (carry_q),
    .taken   (taken)
  );

  // Branches never write back, except bl which writes the link address.
  always_comb begin
    nxt.wb_en   = in_wr_en;
    nxt.wb_rd   = in_rd;
    nxt.wb_data = in_result;
    if (is_bl) begin
      nxt.wb_en   = 1'b1;
      nxt.wb_rd   = LINK_REG;
      nxt.wb_data = in_pc + PC_STEP;
    end else if (br_kind_e'(in_br_type) != BR_NONE) begin
      nxt.wb_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      ent            <= '0;
      carry_q        <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      if (acc) begin
        out_valid <= 1'b1;
        ent       <= nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (acc && in_op_add) carry_q <= in_carry;
      // Pulse is derived from acc only, so a stalled output cannot stretch it.
      redirect_valid <= acc && taken;
      redirect_pc    <= (acc && taken) ? in_br_target : '0;
    end
  end

  assign out_wb_en   = ent.wb_en;
  assign out_wb_rd   = ent.wb_rd;
  assign out_wb_data = ent.wb_data;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage with hand-computed expectations.
module tb_ex_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_zero;
  logic        in_msb;
  logic        in_carry;
  logic        in_op_add;
  logic        in_wr_en;
  logic [4:0]  in_rd;
  logic [2:0]  in_br_type;
  logic [31:0] in_pc;
  logic [31:0] in_br_target;
  logic        out_valid;
  logic        out_ready;
  logic        out_wb_en;
  logic [4:0]  out_wb_rd;
  logic [31:0] out_wb_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        carry_q;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_wb_stage #(.LINK_REG(5'd31)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_msb(in_msb),
    .in_carry(in_carry), .in_op_add(in_op_add), .in_wr_en(in_wr_en),
    .in_rd(in_rd), .in_br_type(in_br_type), .in_pc(in_pc),
    .in_br_target(in_br_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_en(out_wb_en), .out_wb_rd(out_wb_rd), .out_wb_data(out_wb_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .carry_q(carry_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic z, input logic m,
                       input logic cy, input logic add, input logic we, input logic [4:0] rd,
                       input logic [2:0] bt, input logic [31:0] pc, input logic [31:0] tgt);
    in_valid = v; in_result = res; in_zero = z; in_msb = m; in_carry = cy;
    in_op_add = add; in_wr_en = we; in_rd = rd; in_br_type = bt; in_pc = pc;
    in_br_target = tgt;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 1. reset and idle
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_wb_en", {31'd0, out_wb_en}, 0);
    chk("rst_wb_rd", {27'd0, out_wb_rd}, 0);
    chk("rst_wb_data", out_wb_data, 0);
    chk("rst_redir_v", {31'd0, redirect_valid}, 0);
    chk("rst_redir_pc", redirect_pc, 0);
    chk("rst_carry", {31'd0, carry_q}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);

    // 2. add writeback
    rst_n = 1'b1;
    drive(1, 32'hFFFF_FFFF, 0, 1, 1, 1, 1, 5'd3, 3'd0, 32'h10, 0);
    tick();
    chk("add_out_valid", {31'd0, out_valid}, 1);
    chk("add_wb_rd", {27'd0, out_wb_rd}, 3);
    chk("add_wb_data", out_wb_data, 32'hFFFF_FFFF);
    chk("add_wb_en", {31'd0, out_wb_en}, 1);
    chk("add_carry", {31'd0, carry_q}, 1);
    chk("add_no_redir", {31'd0, redirect_valid}, 0);

    // 3. clear carry, add sets it, back-to-back bcy sees it
    drive(1, 32'd7, 0, 0, 0, 1, 1, 5'd2, 3'd0, 32'h14, 0);
    tick();
    chk("add0_carry", {31'd0, carry_q}, 0);
    drive(1, 32'd5, 0, 0, 1, 1, 1, 5'd4, 3'd0, 32'h18, 0);
    tick();
    chk("add1_carry", {31'd0, carry_q}, 1);
    chk("add1_wb_data", out_wb_data, 5);
    drive(1, 32'd9, 0, 0, 0, 0, 1, 5'd6, 3'd6, 32'h1C, 32'h100);
    tick();
    chk("bcy_redir_v", {31'd0, redirect_valid}, 1);
    chk("bcy_redir_pc", redirect_pc, 32'h100);
    chk("bcy_wb_en", {31'd0, out_wb_en}, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("bcy_pulse_end", {31'd0, redirect_valid}, 0);
    chk("drain_out_valid", {31'd0, out_valid}, 0);
    drive(1, 32'd9, 0, 0, 0, 0, 1, 5'd6, 3'd7, 32'h20, 32'h100);
    tick();
    chk("bncy_no_redir", {31'd0, redirect_valid}, 0);
    chk("bncy_out_valid", {31'd0, out_valid}, 1);

    // 4. bl with PC wrap
    drive(1, 32'h1234, 0, 0, 0, 0, 0, 5'd5, 3'd5, 32'hFFFF_FFFC, 32'h40);
    tick();
    chk("bl_wb_rd", {27'd0, out_wb_rd}, 31);
    chk("bl_wb_data", out_wb_data, 0);
    chk("bl_wb_en", {31'd0, out_wb_en}, 1);
    chk("bl_redir_v", {31'd0, redirect_valid}, 1);
    chk("bl_redir_pc", redirect_pc, 32'h40);

    // not-taken bz, taken bltz
    drive(1, 32'd1, 0, 0, 0, 0, 1, 5'd1, 3'd3, 32'h30, 32'h80);
    tick();
    chk("bz_nt_redir", {31'd0, redirect_valid}, 0);
    drive(1, 32'd1, 0, 1, 0, 0, 1, 5'd1, 3'd2, 32'h34, 32'h88);
    tick();
    chk("bltz_redir_pc", redirect_pc, 32'h88);

    // 5. stall with a taken br waiting upstream
    drive(1, 32'hAAAA, 0, 0, 0, 0, 1, 5'd7, 3'd0, 32'h40, 0);
    tick();
    chk("pre_stall_data", out_wb_data, 32'hAAAA);
    out_ready = 1'b0;
    drive(1, 32'hBBBB, 0, 0, 0, 1, 1, 5'd8, 3'd1, 32'h44, 32'h300);
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_out_valid", {31'd0, out_valid}, 1);
      chk("stall_wb_data", out_wb_data, 32'hAAAA);
      chk("stall_wb_rd", {27'd0, out_wb_rd}, 7);
      chk("stall_in_ready", {31'd0, in_ready}, 0);
      chk("stall_no_redir", {31'd0, redirect_valid}, 0);
      chk("stall_carry", {31'd0, carry_q}, 1);
    end
    out_ready = 1'b1;
    tick();
    chk("fill_out_valid", {31'd0, out_valid}, 1);
    chk("fill_wb_data", out_wb_data, 32'hBBBB);
    chk("fill_wb_rd", {27'd0, out_wb_rd}, 8);
    chk("fill_wb_en", {31'd0, out_wb_en}, 0);
    chk("fill_redir_pc", redirect_pc, 32'h300);
    chk("fill_carry", {31'd0, carry_q}, 0);
    drive(1, 32'd3, 0, 0, 1, 1, 1, 5'd9, 3'd0, 32'h48, 0);
    tick();
    chk("b2b_carry", {31'd0, carry_q}, 1);
    chk("b2b_pulse_end", {31'd0, redirect_valid}, 0);

    // 6. reset in the same cycle as a taken bz
    rst_n = 1'b0;
    drive(1, 32'd0, 1, 0, 1, 1, 1, 5'd10, 3'd3, 32'h4C, 32'h200);
    tick();
    chk("rstbr_redir_v", {31'd0, redirect_valid}, 0);
    chk("rstbr_out_valid", {31'd0, out_valid}, 0);
    chk("rstbr_carry", {31'd0, carry_q}, 0);
    chk("rstbr_in_ready", {31'd0, in_ready}, 1);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("post_rst_redir", {31'd0, redirect_valid}, 0);
    chk("post_rst_valid", {31'd0, out_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ex_wb_stage.md
# ex_wb_stage

Execute/writeback stage of KGP_RISC, directly downstream of the ALU. Registers the ALU result for register-file writeback, holds the architectural carry flag, and resolves conditional branches from the ALU flags. It produces a one-cycle PC redirect. A single-entry valid/ready buffer decouples it from writeback stalls.

## Interface
Parameters
- `LINK_REG`, 5'd31: destination register for `bl` link writes.

Ports
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset, synchronous and active-low.
- `in_valid`  in  1  Upstream holds a valid executed instruction.
- `in_ready`  out  1  Stage can accept this cycle.
- `in_result`  in  32  ALU `out`.
- `in_zero`  in  1  ALU zero flag (operand 1 == 0).
- `in_msb`  in  1  ALU msb flag (operand 1 bit 31).
- `in_carry`  in  1  ALU carry-out of the add path.
- `in_op_add`  in  1  Instruction is an add-class op; carry register updates.
- `in_wr_en`  in  1  Instruction writes `in_rd`.
- `in_rd`  in  5  Destination register.
- `in_br_type`  in  3  Branch kind (see Operation).
- `in_pc`  in  32  PC of the instruction.
- `in_br_target`  in  32  Resolved branch target address.
- `out_valid`  out  1  Writeback entry valid.
- `out_ready`  in  1  Register file consumes the entry.
- `out_wb_en`  out  1  Write enable for the register file.
- `out_wb_rd`  out  5  Write address.
- `out_wb_data`  out  32  Write data.
- `redirect_valid`  out  1  One-cycle pulse: a taken branch was accepted.
- `redirect_pc`  out  32  Target PC, valid only while `redirect_valid` is high.
- `carry_q`  out  1  Architectural carry flag.

## Operation
- Accept: `acc = in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational, and there is no bubble on simultaneous drain and fill.
- Branch kinds (`in_br_type`):
  - 0: none.
  - 1: `br`, unconditional.
  - 2: `bltz`, taken if `in_msb`.
  - 3: `bz`, taken if `in_zero`.
  - 4: `bnz`, taken if `!in_zero`.
  - 5: `bl`, unconditional plus link.
  - 6: `bcy`, taken if `carry_q`.
  - 7: `bncy`, taken if `!carry_q`.
- `bcy` and `bncy` use the registered `carry_q` as it stood before this cycle's update.
- On `acc`:
  - The entry is loaded.
  - `out_wb_data` is `in_pc + 4` for `bl`, else `in_result`.
  - `out_wb_rd` is `LINK_REG` for `bl`, else `in_rd`.
  - `out_wb_en` is `1` for `bl`, else `in_wr_en`.
  - For kinds 1–7, `out_wb_en` is forced to 0 unless the kind is `bl`.
- Carry register: if `acc && in_op_add`, then `carry_q <= in_carry`. Otherwise `carry_q` holds.
- Redirect: if `acc` and the branch is taken, then on the next cycle `redirect_valid = 1` and `redirect_pc = in_br_target`. Otherwise `redirect_valid = 0`. Upstream flushes on the pulse.
- Entry state:
  - `out_valid` is set on `acc`.
  - `out_valid` is cleared on `out_ready && !acc`.
  - `out_valid` holds otherwise.
- All arithmetic is 32-bit modulo; `in_pc + 4` wraps at 2^32.

## Timing
- Latency: 1 cycle from `acc` to `out_valid` and to `redirect_valid`.
- Reset (`rst_n == 0` at the edge): `out_valid`, `out_wb_en`, `out_wb_rd`, `out_wb_data`, `redirect_valid`, `redirect_pc` and `carry_q` all go to 0.
- Reset mid-operation discards any held entry and any pending redirect; no redirect pulse is emitted after reset.
- `in_ready` is 1 during and immediately after reset.
- Stall: while `out_valid && !out_ready`, the entry and all `out_*` signals hold stable and `in_ready` is 0.
- `carry_q` cannot change while stalled, because `acc` is 0.
- `redirect_valid` never lasts more than 1 cycle per accepted branch, even when the output is stalled afterwards.
- Back-to-back: with `out_ready` held at 1, the stage accepts every cycle.
- Add then `bcy`, back-to-back: the `bcy` sees the add's carry, because the update is visible one cycle after the add's `acc`.

## Structure
- Shared package `kgp_pkg`: branch-kind constants (`BR_NONE` … `BR_NCY`), `LINK_REG` default, and the `PC_STEP = 4` constant.
- Sub-module `branch_cond`: combinational taken-evaluation from `in_br_type`, `in_zero`, `in_msb` and `carry_q`.
- The top level holds the entry register, the carry register and the redirect register.

## Test plan
1. Reset then idle: hold `rst_n = 0` for 2 cycles.
   - All outputs are 0 and `in_ready = 1`.
2. Add writeback: accept `in_result = 0xFFFFFFFF`, `in_op_add = 1`, `in_carry = 1`, `in_rd = 3`, `in_wr_en = 1`.
   - Next cycle: `out_valid = 1`, `out_wb_rd = 3`, `out_wb_data = 0xFFFFFFFF`, `carry_q = 1`.
3. Carry branch: accept add with `in_carry = 1`, then back-to-back `bcy` with `in_br_target = 0x100`.
   - `redirect_valid` pulses 1 cycle with `redirect_pc = 0x100`.
   - Repeat with `bncy`: no redirect.
4. Link: accept `bl` with `in_pc = 0xFFFFFFFC`, `in_br_target = 0x40`.
   - `out_wb_rd = 31`, `out_wb_data = 0x0` (wrap), `out_wb_en = 1`, redirect to `0x40`.
5. Stall: `out_ready = 0` with `in_valid = 1` for 3 cycles.
   - Outputs stable and `in_ready = 0`.
   - On `out_ready = 1` with `in_valid = 1`: drain and fill in the same cycle, and `out_valid` stays 1 with the new data.
6. Reset mid-branch: accept a taken `bz` (`in_zero = 1`) while `rst_n = 0` in the same cycle.
   - No redirect, `out_valid = 0`, `carry_q = 0`.
